canny_frame_sequencer: RTL and testbench

- Frame-level controller in front of the 3x3 Sobel window line buffer.
- Latches the frame geometry on start and flushes the buffer's line FIFOs with a reset pulse.
- Paces the pixel stream into the buffer, inserting a row gap after every line.
- Counts window outputs and reports frame completion, config errors and drain timeouts to the host.

---
 rtl/canny_pkg.sv | 29 ++
 rtl/canny_raster_counter.sv | 52 +++++
 rtl/canny_frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_canny_frame_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared types and constants for the Canny frame sequencer
package canny_pkg;

    localparam int PIX_CNT_W = 22;
    localparam int DIM_W     = 11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_CFG = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    // Number of full 3x3 windows a frame of iw x ih pixels produces.
    function automatic logic [PIX_CNT_W-1:0] window_count(input logic [DIM_W-1:0] iw,
                                                          input logic [DIM_W-1:0] ih);
        logic [PIX_CNT_W-1:0] w;
        logic [PIX_CNT_W-1:0] h;
        w = PIX_CNT_W'(iw) - PIX_CNT_W'(2);
        h = PIX_CNT_W'(ih) - PIX_CNT_W'(2);
        return w * h;
    endfunction

endpackage

// File: rtl/canny_raster_counter.sv
// rtl/canny_raster_counter.sv - column/row raster position with end-of-line gap timer
module canny_raster_counter
    import canny_pkg::*;
#(
    parameter int LINE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [DIM_W-1:0] iw,
    input  logic [DIM_W-1:0] ih,
    output logic             last,
    output logic             gap
);

    localparam int GAP_W = 4;

    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic [GAP_W-1:0] gap_cnt;
    logic             col_end;

    assign col_end = (col == iw - DIM_W'(1));
    assign last    = col_end && (row == ih - DIM_W'(1));
    assign gap     = (gap_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col     <= '0;
            row     <= '0;
            gap_cnt <= '0;
        end else begin
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= row + DIM_W'(1);
                    // The final row needs no gap; the frame drains instead.
                    if (!last) begin
                        gap_cnt <= GAP_W'(LINE_GAP);
                    end
                end else begin
                    col <= col + DIM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/canny_frame_sequencer.sv
// rtl/canny_frame_sequencer.sv - frame controller pacing pixels into the 3x3 window buffer
module canny_frame_sequencer
    import canny_pkg::*;
#(
    parameter int DATAWID   = 40,
    parameter int CLR_CYC   = 4,
    parameter int LINE_GAP  = 2,
    parameter int DRAIN_TMO = 4096,
    parameter int MAX_DIM   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_iw,
    input  logic [DIM_W-1:0]   cfg_ih,
    input  logic               src_valid,
    input  logic [DATAWID-1:0] src_data,
    output logic               src_ready,
    output logic               buf_rst,
    output logic               buf_din_valid,
    output logic [DATAWID-1:0] buf_din,
    output logic [DIM_W-1:0]   buf_iw,
    output logic [DIM_W-1:0]   buf_ih,
    input  logic               buf_dout_valid,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    localparam int CYC_W = $clog2(DRAIN_TMO + 1);

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [CYC_W-1:0]     cyc_cnt;
    logic [PIX_CNT_W-1:0] out_cnt;
    logic [PIX_CNT_W-1:0] out_cnt_nxt;
    logic [PIX_CNT_W-1:0] target;
    logic                 last_pix;
    logic                 in_gap;
    logic                 accept;
    logic                 cfg_ok;
    logic                 drain_hit;
    logic                 drain_tmo;

    assign cfg_ok = (cfg_iw >= DIM_W'(3)) && (cfg_iw <= DIM_W'(MAX_DIM)) &&
                    (cfg_ih >= DIM_W'(3)) && (cfg_ih <= DIM_W'(MAX_DIM));
    assign accept = src_valid && src_ready;

    // Saturating at the target keeps a spurious extra strobe from skipping the match.
    assign out_cnt_nxt = ((state == STREAM || state == DRAIN) && buf_dout_valid && out_cnt != target)
                         ? out_cnt + PIX_CNT_W'(1) : out_cnt;

    // Completion looks at the next count so done follows the last window by one cycle.
    assign drain_hit = (state == DRAIN) && (out_cnt_nxt == target);
    assign drain_tmo = (state == DRAIN) && !drain_hit && (cyc_cnt == CYC_W'(DRAIN_TMO - 1));

    canny_raster_counter #(
        .LINE_GAP(LINE_GAP)
    ) u_raster (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .accept(accept),
        .iw    (buf_iw),
        .ih    (buf_ih),
        .last  (last_pix),
        .gap   (in_gap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        src_ready = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = cfg_ok ? CLEAR : DONE;
                end
            end
            CLEAR: begin
                if (cyc_cnt == CYC_W'(CLR_CYC - 1)) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                src_ready = !in_gap;
                if (src_valid && !in_gap && last_pix) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_hit || drain_tmo) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt       <= '0;
            out_cnt       <= '0;
            target        <= '0;
            buf_rst       <= 1'b1;
            buf_din_valid <= 1'b0;
            buf_din       <= '0;
            buf_iw        <= '0;
            buf_ih        <= '0;
            err           <= ERR_OK;
        end else begin
            // One shared dwell counter, restarted on every state change.
            cyc_cnt       <= (state_nxt != state) ? '0 : cyc_cnt + CYC_W'(1);
            out_cnt       <= out_cnt_nxt;
            buf_rst       <= (state_nxt == CLEAR);
            buf_din_valid <= accept;
            if (accept) begin
                buf_din <= src_data;
            end
            if (state == IDLE && start) begin
                buf_iw  <= cfg_iw;
                buf_ih  <= cfg_ih;
                target  <= window_count(cfg_iw, cfg_ih);
                out_cnt <= '0;
                err     <= cfg_ok ? ERR_OK : ERR_CFG;
            end
            if (drain_tmo) begin
                err <= ERR_TMO;
            end
        end
    end

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// tb/tb_canny_frame_sequencer.sv - directed self-checking bench for canny_frame_sequencer
module tb_canny_frame_sequencer;

    localparam int DW     = 40;
    localparam int CLR    = 4;
    localparam int GAP    = 2;
    localparam int TMO    = 4096;
    localparam int MAXD   = 1024;
    localparam int BUDGET = 6000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [10:0]   cfg_iw = '0;
    logic [10:0]   cfg_ih = '0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          buf_dout_valid = 1'b0;
    logic          src_ready;
    logic          buf_rst;
    logic          buf_din_valid;
    logic [DW-1:0] buf_din;
    logic [10:0]   buf_iw;
    logic [10:0]   buf_ih;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    canny_frame_sequencer #(
        .DATAWID(DW), .CLR_CYC(CLR), .LINE_GAP(GAP), .DRAIN_TMO(TMO), .MAX_DIM(MAXD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_iw(cfg_iw), .cfg_ih(cfg_ih),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .buf_rst(buf_rst), .buf_din_valid(buf_din_valid), .buf_din(buf_din),
        .buf_iw(buf_iw), .buf_ih(buf_ih), .buf_dout_valid(buf_dout_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int            f_iw = 5, f_ih = 4, f_withhold = 0;
    bit            f_toggle = 0, f_feed = 0, f_poke = 0;
    logic [DW-1:0] f_base = '0;
    int            cyc = 0, acc_cnt, din_cnt, din_err, win_cnt, dout_cnt, last_dout_cyc;
    int            rst_cyc, ready_cnt, gap_runs, gap_err, low_run;
    int            done_cnt, done_cyc, drain_cyc, start_cyc;
    logic [1:0]    done_err;
    bit            in_stream, prev_rst_hi;

    // One clock: note the accept about to happen, sample after the edge, update the
    // window-buffer model and scoreboards, then drive the next cycle's inputs.
    task automatic step();
        bit acc;
        bit win;
        int r, c, npix;
        acc  = src_valid && src_ready && !rst;
        npix = f_iw * f_ih;
        @(posedge clk);
        #1;
        cyc++;
        win = 0;
        if (acc) acc_cnt++;
        if (buf_din_valid !== acc) din_err++;
        if (buf_din_valid) begin
            if (buf_din !== f_base + DW'(din_cnt)) din_err++;
            r = din_cnt / f_iw;
            c = din_cnt % f_iw;
            win = (r >= 2) && (c >= 2);
            din_cnt++;
        end
        buf_dout_valid = 1'b0;
        if (win) begin
            win_cnt++;
            if (win_cnt <= (f_iw - 2) * (f_ih - 2) - f_withhold) begin
                buf_dout_valid = 1'b1;
                dout_cnt++;
                last_dout_cyc = cyc;
            end
        end
        if (busy && buf_rst) rst_cyc++;
        if (busy && !buf_rst && prev_rst_hi) in_stream = 1;
        prev_rst_hi = busy && buf_rst;
        if (acc && acc_cnt == npix) begin
            in_stream = 0;
            drain_cyc = cyc;
        end
        if (src_ready) ready_cnt++;
        if (in_stream) begin
            if (!src_ready) begin
                low_run++;
                if (low_run == 1 && (acc_cnt % f_iw) != 0) gap_err++;
            end else if (low_run != 0) begin
                if (low_run != GAP) gap_err++;
                gap_runs++;
                low_run = 0;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
        src_valid = f_feed && (acc_cnt < npix) && (!f_toggle || (cyc % 2 == 0));
        src_data  = f_base + DW'(acc_cnt);
        start     = f_poke && ((acc_cnt == 7 && src_ready) || done);
        cfg_iw    = start ? 11'd9 : 11'(f_iw);
    endtask

    task automatic run_frame(input int iw, input int ih, input bit toggle, input int withhold,
                             input bit poke, input int abort_at, input logic [DW-1:0] base);
        int n;
        f_iw = iw; f_ih = ih; f_toggle = toggle; f_withhold = withhold;
        f_poke = poke; f_feed = 1; f_base = base;
        acc_cnt = 0; din_cnt = 0; din_err = 0; win_cnt = 0; dout_cnt = 0; last_dout_cyc = 0;
        rst_cyc = 0; ready_cnt = 0; gap_runs = 0; gap_err = 0; low_run = 0;
        done_cnt = 0; done_cyc = 0; drain_cyc = 0; done_err = 2'b11;
        in_stream = 0; prev_rst_hi = 0;
        cfg_iw = 11'(iw);
        cfg_ih = 11'(ih);
        start  = 1'b1;
        step();
        start_cyc = cyc;
        n = 0;
        while (done_cnt == 0 && n < BUDGET && !(abort_at > 0 && acc_cnt >= abort_at)) begin
            step();
            n++;
        end
        f_feed    = 0;
        src_valid = 1'b0;
    endtask

    initial begin
        bit busy_seen;

        step();
        step();
        check_eq("rst_ctl", 64'({src_ready, buf_rst, buf_din_valid, busy, done, err}), 64'h20);
        check_eq("rst_data", 64'({buf_din, buf_iw, buf_ih}), 64'h0);
        rst = 1'b0;
        step();
        check_eq("idle_quiet", 64'({buf_rst, busy, src_ready}), 64'h0);

        // 5x4 continuous stream
        run_frame(5, 4, 0, 0, 0, 0, 40'hA0_0000_0000);
        check_eq("a_clear_len", 64'(rst_cyc), 64'(CLR));
        check_eq("a_accepts", 64'(acc_cnt), 64'd20);
        check_eq("a_din_pulses", 64'(din_cnt), 64'd20);
        check_eq("a_din_err", 64'(din_err), 64'd0);
        check_eq("a_gap_runs", 64'(gap_runs), 64'd3);
        check_eq("a_gap_err", 64'(gap_err), 64'd0);
        check_eq("a_dout", 64'(dout_cnt), 64'd6);
        check_eq("a_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("a_done_lat", 64'(done_cyc - last_dout_cyc), 64'd1);
        check_eq("a_err", 64'(done_err), 64'd0);
        step();
        check_eq("a_idle", 64'({busy, done, err}), 64'h0);

        // bad geometry finishes immediately
        run_frame(2, 8, 0, 0, 0, 0, 40'hB0_0000_0000);
        check_eq("b_done_now", 64'(done_cyc - start_cyc), 64'd0);
        check_eq("b_err", 64'(done_err), 64'd1);
        check_eq("b_no_clear", 64'(rst_cyc), 64'd0);
        check_eq("b_no_ready", 64'(ready_cnt), 64'd0);
        step();
        check_eq("b_err_hold", 64'({busy, err}), 64'h1);

        // 4x3 with src_valid every other cycle
        run_frame(4, 3, 1, 0, 0, 0, 40'hC0_0000_0000);
        check_eq("c_accepts", 64'(acc_cnt), 64'd12);
        check_eq("c_din_err", 64'(din_err), 64'd0);
        check_eq("c_gap_runs", 64'(gap_runs), 64'd2);
        check_eq("c_gap_err", 64'(gap_err), 64'd0);
        check_eq("c_dout", 64'(dout_cnt), 64'd2);
        check_eq("c_err", 64'(done_err), 64'd0);
        step();

        // two windows withheld: drain timeout
        run_frame(5, 4, 0, 2, 0, 0, 40'hD0_0000_0000);
        check_eq("d_dout", 64'(dout_cnt), 64'd4);
        check_eq("d_tmo_lat", 64'(done_cyc - drain_cyc), 64'(TMO));
        check_eq("d_err", 64'(done_err), 64'd2);
        step();

        // reset after the 9th accept aborts the frame
        run_frame(5, 4, 0, 0, 0, 9, 40'hE0_0000_0000);
        check_eq("e_at9", 64'(acc_cnt), 64'd9);
        rst = 1'b1;
        step();
        check_eq("e_rst_ctl", 64'({src_ready, buf_rst, buf_din_valid, busy, done, err}), 64'h20);
        check_eq("e_rst_data", 64'({buf_din, buf_iw, buf_ih}), 64'h0);
        rst = 1'b0;
        repeat (3) step();
        check_eq("e_no_done", 64'(done_cnt), 64'd0);
        run_frame(5, 4, 0, 0, 0, 0, 40'hE1_0000_0000);
        check_eq("e2_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("e2_dout", 64'(dout_cnt), 64'd6);
        check_eq("e2_err", 64'(done_err), 64'd0);
        step();

        // start pulsed mid-stream and in the DONE cycle
        run_frame(5, 4, 0, 0, 1, 0, 40'hF0_0000_0000);
        check_eq("f_done_cnt", 64'(done_cnt), 64'd1);
        busy_seen = 0;
        repeat (6) begin
            step();
            busy_seen |= busy;
        end
        f_poke = 0;
        check_eq("f_busy_idle", 64'(busy_seen), 64'd0);
        check_eq("f_done_total", 64'(done_cnt), 64'd1);
        check_eq("f_iw_kept", 64'(buf_iw), 64'd5);
        check_eq("f_err", 64'(done_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
